axi_bram_responder: RTL and testbench

On-chip AXI3-style responder that terminates the frame-buffer AXI master port in place of the DDR controller. It serves INCR write and read bursts from a byte-enabled block RAM. Uses: DDR-less bring-up, loopback of the frame write/read path, and simulation of the frame buffer at reduced resolution. Its AW/W/AR/R signalling is the mirror image of the master side: this block drives `awready`, `wready`, `wlast`, `arready`, `rdata`, `rvalid`, `rlast` and `rid`.

---
 rtl/axi_bram_responder_pkg.sv | 10 +
 rtl/axi_bram_responder_bram.sv | 34 +++
 rtl/axi_bram_responder.sv | 150 +++++++++++++++
 tb/tb_axi_bram_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bram_responder_pkg.sv
// Shared types and constants for the AXI block-RAM responder.
package axi_bram_responder_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, BRESP} state_t;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam int         BEAT_ADDR_LSB = 3;

endpackage

// File: rtl/axi_bram_responder_bram.sv
// Simple dual-port RAM: per-byte write enable, registered read with enable.
// The read register clears on reset so the beat output starts at zero.
module bram_sdp_be #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++)
      if (we_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_bram_responder.sv
// AXI3-style INCR burst responder backed by a byte-enabled block RAM.
// Define AXI_BRAM_BCHAN_EN to add the write-response (B) channel.
module axi_bram_responder
  import axi_bram_responder_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 32,
  parameter int RAM_ADDR_WIDTH  = 10
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rst,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [3:0]                 axi_awid,
  input  logic [3:0]                 axi_awlen,
  input  logic [2:0]                 axi_awsize,
  input  logic [1:0]                 axi_awburst,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
  input  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic                       axi_wlast,
`ifdef AXI_BRAM_BCHAN_EN
  output logic [3:0]                 axi_bid,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
`endif
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [3:0]                 axi_arid,
  input  logic [3:0]                 axi_arlen,
  input  logic [2:0]                 axi_arsize,
  input  logic [1:0]                 axi_arburst,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  input  logic                       axi_rready,
  output logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata,
  output logic                       axi_rvalid,
  output logic                       axi_rlast,
  output logic [3:0]                 axi_rid
);

  localparam int                        BEAT_W  = MEM_DQ_WIDTH * 8;
  localparam int                        IDX_MSB = RAM_ADDR_WIDTH + BEAT_ADDR_LSB - 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] IDX_ONE = 1;

  state_t                    state_q;
  logic [RAM_ADDR_WIDTH-1:0] idx_q;
  logic [4:0]                cnt_q;
  logic [3:0]                id_q;
  logic                      prio_q;   // 1: read wins the next simultaneous request
  logic                      rvalid_q, rlast_q;
  logic                      idle, aw_win, wr_fire, rd_en;

  // Only INCR is served; size/burst and out-of-range address bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{axi_awaddr, axi_araddr, axi_awsize, axi_arsize,
                       axi_awburst ^ BURST_INCR, axi_arburst ^ BURST_INCR};

  assign idle        = (state_q == IDLE) && !ddr_rst;
  assign aw_win      = axi_awvalid && (!axi_arvalid || !prio_q);
  assign axi_awready = idle && aw_win;
  assign axi_arready = idle && axi_arvalid && !aw_win;

  assign axi_wready  = (state_q == WRITE);
  assign axi_wlast   = axi_wready && (cnt_q == 5'd1);
  assign wr_fire     = axi_wready && axi_wvalid;

  assign rd_en       = (state_q == READ) && (cnt_q != 5'd0) && (!rvalid_q || axi_rready);
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rid     = id_q;

`ifdef AXI_BRAM_BCHAN_EN
  assign axi_bvalid  = (state_q == BRESP);
  assign axi_bid     = id_q;
  assign axi_bresp   = RESP_OKAY;
`endif

  bram_sdp_be #(.DATA_W(BEAT_W), .ADDR_W(RAM_ADDR_WIDTH)) u_ram (
    .clk_i   (ddr_clk),
    .rst_i   (ddr_rst),
    .we_i    (wr_fire ? axi_wstrb : '0),
    .waddr_i (idx_q),
    .wdata_i (axi_wdata),
    .re_i    (rd_en),
    .raddr_i (idx_q),
    .rdata_o (axi_rdata)
  );

  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      prio_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (axi_awready) begin
            idx_q   <= axi_awaddr[IDX_MSB:BEAT_ADDR_LSB];
            cnt_q   <= {1'b0, axi_awlen} + 5'd1;
            id_q    <= axi_awid;
            prio_q  <= 1'b1;
            state_q <= WRITE;
          end else if (axi_arready) begin
            idx_q   <= axi_araddr[IDX_MSB:BEAT_ADDR_LSB];
            cnt_q   <= {1'b0, axi_arlen} + 5'd1;
            id_q    <= axi_arid;
            prio_q  <= 1'b0;
            state_q <= READ;
          end
        end
        WRITE: begin
          if (axi_wvalid) begin
            idx_q <= idx_q + IDX_ONE;
            cnt_q <= cnt_q - 5'd1;
`ifdef AXI_BRAM_BCHAN_EN
            if (cnt_q == 5'd1) state_q <= BRESP;
`else
            if (cnt_q == 5'd1) state_q <= IDLE;
`endif
          end
        end
        READ: begin
          // The RAM output register doubles as the R skid: it only advances on rd_en.
          if (rd_en) begin
            idx_q    <= idx_q + IDX_ONE;
            cnt_q    <= cnt_q - 5'd1;
            rvalid_q <= 1'b1;
            rlast_q  <= (cnt_q == 5'd1);
          end else if (axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
          end
          if (rvalid_q && axi_rready && rlast_q) state_q <= IDLE;
        end
`ifdef AXI_BRAM_BCHAN_EN
        BRESP: if (axi_bready) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bram_responder.sv
// Scoreboard bench for axi_bram_responder: stimulus pushes expected R beats and
// wlast flags into queues; a negedge monitor pops and compares on each handshake.
module tb_axi_bram_responder;

  localparam int AW  = 28;
  localparam int DQ  = 32;
  localparam int RAW = 10;
  localparam int BW  = DQ * 8;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst = 1'b1;
  logic [AW-1:0] axi_awaddr = '0, axi_araddr = '0;
  logic [3:0]    axi_awid = '0, axi_awlen = '0, axi_arid = '0, axi_arlen = '0;
  logic [2:0]    axi_awsize = 3'd5, axi_arsize = 3'd5;
  logic [1:0]    axi_awburst = 2'b01, axi_arburst = 2'b01;
  logic          axi_awvalid = 1'b0, axi_arvalid = 1'b0, axi_wvalid = 1'b0, axi_rready = 1'b1;
  logic [BW-1:0] axi_wdata = '0;
  logic [DQ-1:0] axi_wstrb = '0;
  logic          axi_awready, axi_wready, axi_wlast, axi_arready, axi_rvalid, axi_rlast;
  logic [BW-1:0] axi_rdata;
  logic [3:0]    axi_rid;
`ifdef AXI_BRAM_BCHAN_EN
  logic [3:0]    axi_bid;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready = 1'b1;
`endif

  always #5 ddr_clk = ~ddr_clk;

  axi_bram_responder #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .RAM_ADDR_WIDTH(RAW)) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_wlast(axi_wlast),
`ifdef AXI_BRAM_BCHAN_EN
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
`endif
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic          last;
    logic [3:0]    id;
  } rexp_t;

  rexp_t rq[$];
  logic  wq[$];
  logic  gq[$];   // grant log: 0 = write, 1 = read
  int    total = 0, bad = 0;
  int    cyc = 0, rcv = 0, rise_cyc = 0, last_cyc = 0;
  logic  rv_prev = 1'b0;

  always @(posedge ddr_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic push_r(input logic [BW-1:0] d, input logic last, input logic [3:0] id);
    rexp_t e;
    e.d = d; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  always @(negedge ddr_clk) begin
    rexp_t e;
    logic  wl;
    if (ddr_rst) rv_prev = 1'b0;
    else begin
      if (axi_rvalid && !rv_prev) rise_cyc = cyc;
      rv_prev = axi_rvalid;
      if (axi_rvalid && axi_rready) begin
        if (rq.size() == 0) tmo("r_unexpected_beat");
        else begin
          e = rq.pop_front();
          chk("rdata", axi_rdata, e.d);
          chk("rlast", BW'(axi_rlast), BW'(e.last));
          chk("rid", BW'(axi_rid), BW'(e.id));
        end
        rcv++;
        if (axi_rlast) last_cyc = cyc;
      end
      if (axi_wvalid && axi_wready) begin
        if (wq.size() == 0) tmo("w_unexpected_beat");
        else begin
          wl = wq.pop_front();
          chk("wlast", BW'(axi_wlast), BW'(wl));
        end
      end
      if (axi_awvalid && axi_awready) gq.push_back(1'b0);
      if (axi_arvalid && axi_arready) gq.push_back(1'b1);
    end
  end

  task automatic aw_cmd(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id);
    axi_awaddr = a; axi_awlen = len; axi_awid = id; axi_awvalid = 1'b1;
  endtask

  task automatic ar_cmd(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id);
    axi_araddr = a; axi_arlen = len; axi_arid = id; axi_arvalid = 1'b1;
  endtask

  task automatic wait_aw(output int h);
    bit ok = 0;
    h = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge ddr_clk);
      if (axi_awready) begin ok = 1; break; end
    end
    if (!ok) tmo("aw_handshake");
    h = cyc;
    @(posedge ddr_clk); #1 axi_awvalid = 1'b0;
  endtask

  task automatic wait_ar(output int h);
    bit ok = 0;
    h = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge ddr_clk);
      if (axi_arready) begin ok = 1; break; end
    end
    if (!ok) tmo("ar_handshake");
    h = cyc;
    @(posedge ddr_clk); #1 axi_arvalid = 1'b0;
  endtask

  // kmode=1 writes beat k with value k, otherwise every beat carries d0.
  task automatic w_data(input int len, input bit kmode, input logic [BW-1:0] d0,
                        input logic [DQ-1:0] strb);
    bit ok;
    int wt;
    for (int k = 0; k <= len; k++) wq.push_back(k == len);
    axi_wvalid = 1'b1;
    axi_wstrb  = strb;
    for (int k = 0; k <= len; k++) begin
      axi_wdata = kmode ? BW'(k) : d0;
      ok = 0; wt = 0;
      for (int n = 0; n < 60; n++) begin
        @(negedge ddr_clk);
        if (axi_wready) begin ok = 1; break; end
        wt++;
      end
      if (!ok) tmo("w_handshake");
      else if (k == 0) chk("wready_latency", BW'(wt), BW'(0));
      @(posedge ddr_clk); #1;
    end
    axi_wvalid = 1'b0;
  endtask

  task automatic r_drain(input int n, input bit toggle);
    int target = rcv + n;
    bit ok = 0;
    axi_rready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge ddr_clk); #1;
      if (rcv >= target) begin ok = 1; break; end
      if (toggle) axi_rready = ~axi_rready;
    end
    if (!ok) tmo("r_drain");
    axi_rready = 1'b1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_awready"}, BW'(axi_awready), '0);
    chk({tag, "_arready"}, BW'(axi_arready), '0);
    chk({tag, "_wready"},  BW'(axi_wready),  '0);
    chk({tag, "_wlast"},   BW'(axi_wlast),   '0);
    chk({tag, "_rvalid"},  BW'(axi_rvalid),  '0);
    chk({tag, "_rlast"},   BW'(axi_rlast),   '0);
    chk({tag, "_rid"},     BW'(axi_rid),     '0);
    chk({tag, "_rdata"},   axi_rdata,        '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    // Reset state, with requests pending so the combinational readies are exercised.
    axi_awvalid = 1'b1; axi_arvalid = 1'b1; axi_wvalid = 1'b1;
    repeat (3) @(posedge ddr_clk);
    #1 chk_outs_zero("reset");
    axi_awvalid = 1'b0; axi_arvalid = 1'b0; axi_wvalid = 1'b0;
    @(posedge ddr_clk); #1 ddr_rst = 1'b0;

    // Single write then read.
    aw_cmd(28'h40, 4'd0, 4'd1); wait_aw(h);
    w_data(0, 0, {32{8'hA5}}, '1);
    ar_cmd(28'h40, 4'd0, 4'd3); push_r({32{8'hA5}}, 1'b1, 4'd3);
    wait_ar(h); r_drain(1, 0);
    chk("rvalid_latency", BW'(rise_cyc - h), BW'(2));

    // 16-beat burst, beat k = k.
    aw_cmd(28'h0, 4'd15, 4'd1); wait_aw(h);
    w_data(15, 1, '0, '1);
    ar_cmd(28'h0, 4'd15, 4'd1);
    for (int k = 0; k < 16; k++) push_r(BW'(k), k == 15, 4'd1);
    wait_ar(h); r_drain(16, 0);
    chk("burst16_last_cycle", BW'(last_cyc - h), BW'(17));

    // Byte strobes: only the low 4 bytes are cleared.
    aw_cmd(28'h100, 4'd0, 4'd2); wait_aw(h); w_data(0, 0, {32{8'hFF}}, '1);
    aw_cmd(28'h100, 4'd0, 4'd2); wait_aw(h); w_data(0, 0, '0, 32'h0000_000F);
    ar_cmd(28'h100, 4'd0, 4'd2); push_r({{28{8'hFF}}, 32'h0}, 1'b1, 4'd2);
    wait_ar(h); r_drain(1, 0);

    // Backpressure: rready toggles during a 4-beat read.
    ar_cmd(28'h0, 4'd3, 4'd6);
    for (int k = 0; k < 4; k++) push_r(BW'(k), k == 3, 4'd6);
    wait_ar(h); r_drain(4, 1);

    // Arbitration: simultaneous AW/AR twice gives W, R, W, R.
    gq.delete();
    aw_cmd(28'h200, 4'd0, 4'd2); ar_cmd(28'h200, 4'd0, 4'd4);
    push_r(BW'(16'h1111), 1'b1, 4'd4);
    wait_aw(h); w_data(0, 0, BW'(16'h1111), '1);
    wait_ar(h); r_drain(1, 0);
    aw_cmd(28'h208, 4'd0, 4'd7); ar_cmd(28'h208, 4'd0, 4'd8);
    push_r(BW'(16'h2222), 1'b1, 4'd8);
    wait_aw(h); w_data(0, 0, BW'(16'h2222), '1);
    wait_ar(h); r_drain(1, 0);
    if (gq.size() == 4) chk("grant_order", BW'({gq[0], gq[1], gq[2], gq[3]}), BW'(4'b0101));
    else chk("grant_count", BW'(gq.size()), BW'(4));

    // Aliasing: beat index 1025 lands on index 1.
    aw_cmd(28'h2008, 4'd0, 4'd1); wait_aw(h); w_data(0, 0, BW'(16'hDEAD), '1);
    ar_cmd(28'h8, 4'd0, 4'd9); push_r(BW'(16'hDEAD), 1'b1, 4'd9);
    wait_ar(h); r_drain(1, 0);

    // Reset during beat 3 of an 8-beat read from index 2.
    ar_cmd(28'h10, 4'd7, 4'd10);
    for (int k = 0; k < 3; k++) push_r(BW'(k + 2), 1'b0, 4'd10);
    wait_ar(h); r_drain(3, 0);
    chk("pre_reset_rvalid", BW'(axi_rvalid), BW'(1));
    axi_awvalid = 1'b1;
    ddr_rst = 1'b1;
    #1 chk_outs_zero("midreset");
    axi_awvalid = 1'b0;
    repeat (2) @(posedge ddr_clk);
    #1 ddr_rst = 1'b0;
    chk("midreset_queue_empty", BW'(rq.size()), BW'(0));
    aw_cmd(28'h40, 4'd0, 4'd12); wait_aw(h); w_data(0, 0, BW'(16'hBEEF), '1);
    ar_cmd(28'h40, 4'd0, 4'd11); push_r(BW'(16'hBEEF), 1'b1, 4'd11);
    wait_ar(h); r_drain(1, 0);
    chk("post_reset_latency", BW'(rise_cyc - h), BW'(2));

`ifdef AXI_BRAM_BCHAN_EN
    // Write response held while bready is low; no new command is granted meanwhile.
    axi_bready = 1'b0;
    aw_cmd(28'h300, 4'd3, 4'd5); wait_aw(h); w_data(3, 1, '0, '1);
    ar_cmd(28'h300, 4'd0, 4'd13); push_r(BW'(0), 1'b1, 4'd13);
    for (int i = 0; i < 3; i++) begin
      @(negedge ddr_clk);
      chk("bvalid_held", BW'(axi_bvalid), BW'(1));
      chk("bid", BW'(axi_bid), BW'(5));
      chk("bresp", BW'(axi_bresp), BW'(0));
      chk("arready_blocked", BW'(axi_arready), BW'(0));
    end
    @(posedge ddr_clk); #1 axi_bready = 1'b1;
    wait_ar(h); r_drain(1, 0);
    chk("bvalid_cleared", BW'(axi_bvalid), BW'(0));
`endif

    repeat (3) @(posedge ddr_clk);
    chk("r_queue_empty", BW'(rq.size()), BW'(0));
    chk("w_queue_empty", BW'(wq.size()), BW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
